cmos_ha_switch_cell: RTL and testbench

Cycle-based switch-level evaluator of a 12-transistor static CMOS half adder (XNOR pass-gate sum path, NAND/inverter carry path). Each clock it resolves every internal node of the nmos/pmos network from four-valued inputs and registers sum, carry and diagnostic flags. Sits in the cell-characterisation harness as the golden switch-level reference against which gate-level half adders are checked.

---
 rtl/cmos_ha_switch_cell.sv | 93 +++++++++
 tb/tb_cmos_ha_switch_cell.sv | 110 +++++++++++
 2 files changed

// File: rtl/cmos_ha_switch_cell.sv
// Switch-level evaluator of a 12-transistor CMOS half adder with four-valued nodes.
// Define NODE_DEBUG_EN to expose the registered internal nodes on dbg_nodes.
module cmos_ha_switch_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic       eval_en,
  input  logic [1:0] in1,
  input  logic [1:0] in2,
  output logic [1:0] out1,
  output logic [1:0] out2,
  output logic       unknown,
  output logic       contention
`ifdef NODE_DEBUG_EN
  ,
  output logic [7:0] dbg_nodes
`endif
);

  localparam logic [1:0] L0 = 2'b00;
  localparam logic [1:0] L1 = 2'b01;
  localparam logic [1:0] LZ = 2'b10;
  localparam logic [1:0] LX = 2'b11;

  // Contribution mask {x, one, zero} that one switch places on its drain.
  function automatic logic [2:0] sw(input logic is_n, input logic [1:0] g, input logic [1:0] s);
    logic [2:0] c;
    c = 3'b000;
    if (g[1]) c = 3'b100;
    else if (g[0] == is_n) begin
      case (s)
        L0:      c = 3'b001;
        L1:      c = 3'b010;
        LX:      c = 3'b100;
        default: c = 3'b000;
      endcase
    end
    return c;
  endfunction

  function automatic logic [1:0] res(input logic [2:0] c);
    logic [1:0] v;
    if (c == 3'b000)     v = LZ;
    else if (c[1] && c[0]) v = LX;
    else if (c[2])       v = LX;
    else if (c[1])       v = L1;
    else                 v = L0;
    return v;
  endfunction

  logic [2:0] c_w3, c_w9, c_w6, c_w8, c_o1, c_o2;
  logic [1:0] w3, w9, w6, w8, o1, o2;
  logic       cont_n;

  always_comb begin
    c_w3 = sw(1'b0, in1, L1) | sw(1'b1, in1, L0);
    w3   = res(c_w3);
    c_w9 = sw(1'b1, in1, L0);
    w9   = res(c_w9);
    c_w6 = sw(1'b0, in2, w3) | sw(1'b1, in2, in1);
    w6   = res(c_w6);
    c_w8 = sw(1'b0, in2, L1) | sw(1'b0, in1, L1) | sw(1'b1, in2, w9);
    w8   = res(c_w8);
    c_o1 = sw(1'b0, w6, L1) | sw(1'b1, w6, L0);
    o1   = res(c_o1);
    c_o2 = sw(1'b0, w8, L1) | sw(1'b1, w8, L0);
    o2   = res(c_o2);
    // Contention only counts definite opposing drivers, not X contributions.
    cont_n = (c_w3[1] & c_w3[0]) | (c_w9[1] & c_w9[0]) | (c_w6[1] & c_w6[0]) |
             (c_w8[1] & c_w8[0]) | (c_o1[1] & c_o1[0]) | (c_o2[1] & c_o2[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out1       <= L0;
      out2       <= L0;
      unknown    <= 1'b0;
      contention <= 1'b0;
    end else if (eval_en) begin
      out1       <= o1;
      out2       <= o2;
      unknown    <= o1[1] | o2[1];
      contention <= cont_n;
    end
  end

`ifdef NODE_DEBUG_EN
  always_ff @(posedge clk) begin
    if (rst)          dbg_nodes <= 8'h00;
    else if (eval_en) dbg_nodes <= {w3, w6, w8, w9};
  end
`endif

endmodule

// File: tb/tb_cmos_ha_switch_cell.sv
// Scoreboard bench: driver pushes hand-computed expectations, monitor pops after each edge.
module tb_cmos_ha_switch_cell;
  logic       clk = 1'b0;
  logic       rst, eval_en;
  logic [1:0] in1, in2, out1, out2;
  logic       unknown, contention;
`ifdef NODE_DEBUG_EN
  logic [7:0] dbg_nodes;
`endif

  always #5 clk = ~clk;

  cmos_ha_switch_cell dut (
    .clk(clk), .rst(rst), .eval_en(eval_en), .in1(in1), .in2(in2),
    .out1(out1), .out2(out2), .unknown(unknown), .contention(contention)
`ifdef NODE_DEBUG_EN
    , .dbg_nodes(dbg_nodes)
`endif
  );

  typedef struct {
    logic [1:0] o1, o2;
    logic       unk, cont;
    logic       dchk;
    logic [7:0] dbg;
  } exp_t;

  typedef struct {
    logic       rst, en;
    logic [1:0] a, b;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic r, logic en, logic [1:0] a, logic [1:0] b,
                              logic [1:0] o1, logic [1:0] o2, logic u, logic c,
                              logic dchk = 1'b0, logic [7:0] dbg = 8'h00);
    vec_t v;
    v.rst = r; v.en = en; v.a = a; v.b = b;
    v.e.o1 = o1; v.e.o2 = o2; v.e.unk = u; v.e.cont = c; v.e.dchk = dchk; v.e.dbg = dbg;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    //          rst en  in1    in2    out1   out2   unk cont
    vecs.push_back(mk(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0));  // reset
    vecs.push_back(mk(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));  // exhaustive definite
    vecs.push_back(mk(0, 1, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 1, 8'b00_01_00_00));
    vecs.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 1, 8'b00_01_00_00)); // hold
    vecs.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));  // re-enable
    vecs.push_back(mk(0, 1, 2'b01, 2'b11, 2'b11, 2'b11, 1, 0));  // X on in2
    vecs.push_back(mk(0, 1, 2'b10, 2'b00, 2'b11, 2'b11, 1, 0));  // Z on in1
    vecs.push_back(mk(0, 0, 2'b00, 2'b00, 2'b11, 2'b11, 1, 0));  // flags hold
    vecs.push_back(mk(0, 1, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0));  // flags clear
    vecs.push_back(mk(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0));  // reset mid-stream
    vecs.push_back(mk(0, 1, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 1, 0));  // X on in1
    vecs.push_back(mk(0, 1, 2'b00, 2'b10, 2'b11, 2'b11, 1, 0));  // Z on in2
    vecs.push_back(mk(0, 1, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));  // reset beats eval_en=0
    vecs.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 8'b01_01_01_10));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; eval_en = vecs[i].en; in1 = vecs[i].a; in2 = vecs[i].b;
      sb.push_back(vecs[i].e);
      @(posedge clk);
      #2;
    end
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  always begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (out1 !== e.o1 || out2 !== e.o2 || unknown !== e.unk || contention !== e.cont) begin
        n_err++;
        $display("FAIL vec%0d: got out1=%b out2=%b unk=%b cont=%b, want out1=%b out2=%b unk=%b cont=%b",
                 n_cmp, out1, out2, unknown, contention, e.o1, e.o2, e.unk, e.cont);
      end
`ifdef NODE_DEBUG_EN
      if (e.dchk && dbg_nodes !== e.dbg) begin
        n_err++;
        $display("FAIL dbg%0d: got dbg_nodes=%b, want %b", n_cmp, dbg_nodes, e.dbg);
      end
`endif
    end
  end
endmodule
